// File: rtl/mem_port_arbiter_pkg.sv
// cu_pkg: shared arbiter state/requester types and the memory-latency legality bound
package cu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {REQ_IF, REQ_LS} req_id_t;
  localparam int MIN_MEM_LATENCY = 1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata, ls_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: LS-priority winner select, overridden in favour of IF when the starve flag is set
module mem_arb_pick import cu_pkg::*; (
  input  logic    i_if_req,
  input  logic    i_ls_req,
  input  logic    i_starve,
  output logic    o_valid,
  output req_id_t o_win
);
  assign o_valid = i_if_req | i_ls_req;
  assign o_win   = (i_ls_req && !(i_starve && i_if_req)) ? REQ_LS : REQ_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and load/store (LS), one access in flight.
// Define MEM_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT LS grants made while IF waits.
module mem_port_arbiter import cu_pkg::*; #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  if (MEM_LATENCY < MIN_MEM_LATENCY || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: MEM_LATENCY and STARVE_LIMIT must be at least 1");
  end
  arb_state_t        r_state, w_state_nxt;
  req_id_t           r_win, w_pick;
  logic              w_pick_valid, w_starve, w_sample, w_last_wait, w_issue, w_ls_pick;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_if_gnt, r_ls_gnt, r_if_rvalid, r_ls_rvalid, r_mem_en, r_mem_we, r_busy;
  logic [DATA_W-1:0] r_if_rdata, r_ls_rdata, r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  mem_arb_pick u_pick (
    .i_if_req (bus.if_req),
    .i_ls_req (bus.ls_req),
    .i_starve (w_starve),
    .o_valid  (w_pick_valid),
    .o_win    (w_pick)
  );
  assign w_ls_pick   = w_pick == REQ_LS;
  assign w_sample    = (r_state == IDLE) || (r_state == RESP);
  assign w_last_wait = (r_state == WAIT) && (r_cnt == CNT_W'(MEM_LATENCY - 1));
  always_comb begin
    w_issue     = w_sample && w_pick_valid;
    w_state_nxt = w_sample ? (w_pick_valid ? ISSUE : IDLE)
                : (r_state == ISSUE) ? WAIT
                : w_last_wait ? RESP : WAIT;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_win       <= REQ_IF;
      r_we        <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_ls_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt       <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
      r_if_gnt    <= w_issue && !w_ls_pick;
      r_ls_gnt    <= w_issue && w_ls_pick;
      r_mem_en    <= w_issue;
      r_mem_we    <= w_issue && w_ls_pick && bus.ls_we;
      r_busy      <= w_state_nxt != IDLE;
      r_if_rvalid <= w_last_wait && r_win == REQ_IF;
      r_ls_rvalid <= w_last_wait && r_win == REQ_LS;
      if (w_issue) begin
        r_win       <= w_pick;
        r_we        <= w_ls_pick && bus.ls_we;
        r_mem_addr  <= w_ls_pick ? bus.ls_addr : bus.if_addr;
        r_mem_wdata <= w_ls_pick ? bus.ls_wdata : '0;
      end
      if (w_last_wait && r_win == REQ_IF) r_if_rdata <= bus.mem_rdata;
      if (w_last_wait && r_win == REQ_LS) r_ls_rdata <= r_we ? '0 : bus.mem_rdata;
    end
  end
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] r_starve;
  assign w_starve = r_starve >= SC_W'(STARVE_LIMIT);
  // only LS grants that bypass a waiting IF count; every other grant clears
  always_ff @(posedge clk or negedge rst)
    if (!rst)         r_starve <= '0;
    else if (w_issue) r_starve <= (w_ls_pick && bus.if_req) ? r_starve + 1'b1 : '0;
`else
  assign w_starve = 1'b0;
`endif
  assign bus.if_gnt    = r_if_gnt;
  assign bus.ls_gnt    = r_ls_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 7, DW = 32, LAT = 1, LIM = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  int cyc = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3), .STARVE_LIMIT(LIM)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3));

  function automatic logic [DW-1:0] init_val(int a);
    return (a == 5) ? 32'h0000_1234 : 32'h9E37_79B9 * (a + 1);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // memory behind the main DUT: one-cycle read latency, garbage when not reading
  logic [DW-1:0] mem_arr [128];
  logic [DW-1:0] rd_q;
  bit mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 128; i++) mem_arr[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    rd_q <= (bus.mem_en && !bus.mem_we) ? mem_arr[bus.mem_addr] : DW'($urandom);
  end
  assign bus.mem_rdata  = rd_q;
  assign bus3.mem_rdata = 32'hA000_0000 + DW'(cyc);

  // transaction-level model: one transaction at a time, scheduled by cycle number
  logic [DW-1:0] ref_mem [128];
  bit ref_init = 1'b0, have = 1'b0, t_ls, t_we;
  int g_cyc, r_cyc, free_at = 0, m_cnt = 0;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_data, e_if_rd = '0, e_ls_rd = '0;
  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    if (!rst) begin
      have = 1'b0; m_cnt = 0; e_if_rd = '0; e_ls_rd = '0; free_at = cyc + 1;
      chk("reset_outputs", {bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.mem_en,
          bus.mem_we, bus.busy, |bus.if_rdata, |bus.ls_rdata, |bus.mem_addr, |bus.mem_wdata}, '0);
    end else begin
      if (have && cyc == g_cyc) begin
        t_data = t_we ? '0 : ref_mem[t_addr];
        if (t_we) ref_mem[t_addr] = t_wdata;
      end
      if (have && cyc == r_cyc) begin
        if (t_ls) e_ls_rd = t_data;
        else      e_if_rd = t_data;
      end
      chk("if_gnt", bus.if_gnt, have && cyc == g_cyc && !t_ls);
      chk("ls_gnt", bus.ls_gnt, have && cyc == g_cyc && t_ls);
      chk("mem_en", bus.mem_en, have && cyc == g_cyc);
      chk("mem_we", bus.mem_we, have && cyc == g_cyc && t_we);
      if (have && cyc == g_cyc) begin
        chk("mem_addr", bus.mem_addr, t_addr);
        if (t_we) chk("mem_wdata", bus.mem_wdata, t_wdata);
      end
      chk("if_rvalid", bus.if_rvalid, have && cyc == r_cyc && !t_ls);
      chk("ls_rvalid", bus.ls_rvalid, have && cyc == r_cyc && t_ls);
      chk("if_rdata", bus.if_rdata, e_if_rd);
      chk("ls_rdata", bus.ls_rdata, e_ls_rd);
      chk("busy", bus.busy, have && cyc >= g_cyc && cyc <= r_cyc);
      if (cyc >= free_at && (bus.if_req || bus.ls_req)) begin
        t_ls    = bus.ls_req && !(GUARD && m_cnt >= LIM && bus.if_req);
        m_cnt   = (t_ls && bus.if_req) ? m_cnt + 1 : 0;
        t_we    = t_ls && bus.ls_we;
        t_addr  = t_ls ? bus.ls_addr : bus.if_addr;
        t_wdata = bus.ls_wdata;
        have    = 1'b1;
        g_cyc   = cyc + 1;
        r_cyc   = cyc + LAT + 2;
        free_at = r_cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input bit ls, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      output int g, output int r);
    int n;
    if (ls) begin bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_addr = addr; bus.ls_wdata = wd; end
    else    begin bus.if_req = 1'b1; bus.if_addr = addr; end
    n = 0;
    do begin step(); n++; end while (!(ls ? bus.ls_gnt : bus.if_gnt) && n < 50);
    g = cyc;
    chk("gnt_seen", ls ? bus.ls_gnt : bus.if_gnt, 1'b1);
    chk("mem_we_at_gnt", bus.mem_we, we);
    step();
    if (ls) bus.ls_req = 1'b0;
    else    bus.if_req = 1'b0;
    n = 0;
    while (!(ls ? bus.ls_rvalid : bus.if_rvalid) && n < 50) begin step(); n++; end
    r = cyc;
    chk("rvalid_seen", ls ? bus.ls_rvalid : bus.if_rvalid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int g, r, n, nls, nif;
    bit seen_if, seen_ls;
    bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
    bus3.if_req = 0; bus3.if_addr = 0; bus3.ls_req = 0; bus3.ls_we = 0; bus3.ls_addr = 0; bus3.ls_wdata = 0;
    repeat (3) step();
    rst = 1'b1;
    // fetch from idle: gnt, then rvalid two cycles later
    xact(1'b0, 1'b0, 7'd5, '0, g, r);
    chk("t1_latency", r - g, 2);
    chk("t1_if_rdata", bus.if_rdata, 32'h0000_1234);
    // simultaneous requests: LS first, IF straight out of RESP
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 7'd3; bus.if_req = 1; bus.if_addr = 7'd4;
    step();
    chk("t2_ls_first", {bus.ls_gnt, bus.if_gnt}, 2'b10);
    step(); bus.ls_req = 0;
    chk("t2_busy_wait", bus.busy, 1'b1);
    step();
    chk("t2_ls_rvalid", bus.ls_rvalid, 1'b1);
    chk("t2_ls_rdata", bus.ls_rdata, init_val(3));
    chk("t2_busy_resp", bus.busy, 1'b1);
    step();
    chk("t2_if_gnt_after_resp", bus.if_gnt, 1'b1);
    chk("t2_busy_issue", bus.busy, 1'b1);
    step(); bus.if_req = 0;
    step();
    chk("t2_if_rvalid", bus.if_rvalid, 1'b1);
    chk("t2_if_rdata", bus.if_rdata, init_val(4));
    // store then load back
    xact(1'b1, 1'b1, 7'h10, 32'hDEAD_BEEF, g, r);
    chk("t3_store_ack_rdata", bus.ls_rdata, 32'h0);
    xact(1'b1, 1'b0, 7'h10, '0, g, r);
    chk("t3_load_rdata", bus.ls_rdata, 32'hDEAD_BEEF);
    // reset during WAIT abandons the access
    bus.if_req = 1; bus.if_addr = 7'd9;
    n = 0;
    do begin step(); n++; end while (!bus.if_gnt && n < 20);
    chk("t4_gnt_seen", bus.if_gnt, 1'b1);
    step(); bus.if_req = 0;
    rst = 1'b0;
    #1;
    chk("t4_outputs_zero", {bus.if_gnt, bus.if_rvalid, bus.mem_en, bus.busy, |bus.mem_addr}, '0);
    repeat (3) begin step(); chk("t4_no_rvalid", bus.if_rvalid, 1'b0); end
    rst = 1'b1;
    xact(1'b0, 1'b0, 7'd7, '0, g, r);
    chk("t4_after_latency", r - g, 2);
    chk("t4_after_rdata", bus.if_rdata, init_val(7));
    // continuous LS pressure with IF waiting
    nls = 0; nif = 0; n = 0;
    bus.if_req = 1; bus.if_addr = 7'd2; bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 7'd1;
    while (nif == 0 && nls < 20 && n < 200) begin
      step(); n++;
      if (bus.ls_gnt) nls++;
      if (bus.if_gnt) nif++;
    end
    chk("t5_ls_grants", nls, GUARD ? 4 : 20);
    chk("t5_if_grants", nif, GUARD ? 1 : 0);
    step(); bus.if_req = 0; bus.ls_req = 0;
    repeat (5) step();
    // back-to-back: LS re-requests in its RESP cycle
    xact(1'b1, 1'b0, 7'd8, '0, g, r);
    bus.ls_req = 1; bus.ls_addr = 7'd9; bus.ls_we = 0;
    step();
    chk("t6_b2b_gnt", bus.ls_gnt, 1'b1);
    chk("t6_b2b_gap", cyc - r, 1);
    step(); bus.ls_req = 0;
    step();
    chk("t6_rvalid", bus.ls_rvalid, 1'b1);
    chk("t6_rdata", bus.ls_rdata, init_val(9));
    // randomized traffic checked cycle by cycle by the model
    seen_if = 0; seen_ls = 0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (seen_if) bus.if_req = 0;
      if (seen_ls) bus.ls_req = 0;
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1; bus.if_addr = AW'($urandom);
      end
      if (!bus.ls_req && $urandom_range(0, 1) == 0) begin
        bus.ls_req = 1; bus.ls_we = 1'($urandom); bus.ls_addr = AW'($urandom_range(0, 15));
        bus.ls_wdata = DW'($urandom);
      end
      seen_if = bus.if_gnt; seen_ls = bus.ls_gnt;
    end
    for (int k = 0; k < 60 && (bus.if_req || bus.ls_req || bus.busy); k++) begin
      step();
      if (seen_if) bus.if_req = 0;
      if (seen_ls) bus.ls_req = 0;
      seen_if = bus.if_gnt; seen_ls = bus.ls_gnt;
    end
    chk("drain_idle", {bus.if_req, bus.ls_req, bus.busy}, '0);
    // MEM_LATENCY=3 instance: capture on the third WAIT cycle
    bus3.if_req = 1; bus3.if_addr = 7'h2A;
    n = 0;
    do begin step(); n++; end while (!bus3.if_gnt && n < 20);
    g = cyc;
    chk("t7_gnt", bus3.if_gnt, 1'b1);
    chk("t7_mem_en", bus3.mem_en, 1'b1);
    chk("t7_mem_addr", bus3.mem_addr, 7'h2A);
    step(); bus3.if_req = 0;
    n = 0;
    while (!bus3.if_rvalid && n < 20) begin step(); n++; end
    chk("t7_rvalid", bus3.if_rvalid, 1'b1);
    chk("t7_gap", cyc - g, 4);
    chk("t7_rdata", bus3.if_rdata, 32'hA000_0000 + DW'(g + 3));
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
